// File: rtl/id_ex_elastic_reg.sv
// Elastic ID/EX pipeline register: 2-entry skid buffer with valid/ready handshake and flush.
// Optional macro PIPE_PERF_EN adds saturating stall/bubble performance counters.
module id_ex_elastic_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4,
    parameter int CTRL_WIDTH = 16
`ifdef PIPE_PERF_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [CTRL_WIDTH-1:0]             in_ctrl,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0]   in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CTRL_WIDTH-1:0]             out_ctrl,
    output logic [NUM_WORDS*DATA_WIDTH-1:0]   out_data
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]              stall_cnt,
    output logic [CNT_WIDTH-1:0]              bubble_cnt
`endif
);

    localparam int PW = NUM_WORDS * DATA_WIDTH;

    logic            r_main_valid;
    logic [CTRL_WIDTH-1:0] r_main_ctrl;
    logic [PW-1:0]   r_main_data;
    logic            r_skid_valid;
    logic [CTRL_WIDTH-1:0] r_skid_ctrl;
    logic [PW-1:0]   r_skid_data;

    logic            w_acc;
    logic            w_cons;

    assign w_acc  = in_valid & ~r_skid_valid;
    assign w_cons = r_main_valid & out_ready;

    // All handshake outputs come straight from flops to keep paths short.
    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            // Payload is left in place; zeroed control alone makes the slots harmless.
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
        end else if (!r_main_valid || w_cons) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_ctrl  <= r_skid_ctrl;
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= '0;
            end else if (w_acc) begin
                r_main_valid <= 1'b1;
                r_main_ctrl  <= in_ctrl;
                r_main_data  <= in_data;
            end else begin
                r_main_valid <= 1'b0;
                r_main_ctrl  <= '0;
            end
        end else if (w_acc) begin
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= in_ctrl;
            r_skid_data  <= in_data;
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;

    // Counters saturate and survive flush so a trap storm does not hide history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_main_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (!r_main_valid && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Directed scoreboard bench for id_ex_elastic_reg; expected items queued on accept, checked on consume.
// Covers reset, streaming, back-pressure, flush, reset mid-operation and (PIPE_PERF_EN) counter saturation.
module tb_id_ex_elastic_reg;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int CW = 16;
    localparam int PW = DW * NW;
`ifdef PIPE_PERF_EN
    localparam int KW = 4;
`endif

    typedef struct packed {
        logic [CW-1:0] c;
        logic [PW-1:0] d;
    } item_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [PW-1:0] in_data, out_data;
`ifdef PIPE_PERF_EN
    logic [KW-1:0] stall_cnt, bubble_cnt;
`endif

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

`ifdef PIPE_PERF_EN
    id_ex_elastic_reg #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CTRL_WIDTH(CW), .CNT_WIDTH(KW)) dut (
`else
    id_ex_elastic_reg #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CTRL_WIDTH(CW)) dut (
`endif
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mkData();
        logic [PW-1:0] d;
        for (int i = 0; i < NW; i++) d[i*DW +: DW] = $urandom;
        return d;
    endfunction

    // One clock: scoreboard bookkeeping from the handshake, then sample #1 after the edge.
    task automatic cycle();
        logic acc, cons;
        item_t it;
        acc  = (in_valid === 1'b1) && (in_ready === 1'b1);
        cons = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (cons && !rst && !flush) begin
            chk("sb_nonempty", 160'(sb.size() != 0), 160'(1));
            if (sb.size() != 0) begin
                it = sb.pop_front();
                chk("sb_ctrl", 160'(out_ctrl), 160'(it.c));
                chk("sb_data", 160'(out_data), 160'(it.d));
            end
        end
        if (rst || flush) sb.delete();
        else if (acc) sb.push_back('{c: in_ctrl, d: in_data});
        @(posedge clk);
        #1;
        if (out_valid !== 1'b1) chk("bubble_ctrl_zero", 160'(out_ctrl), 160'(0));
    endtask

    task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic [PW-1:0] d,
                                 input logic ordy);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        cycle();
    endtask

    task automatic checkOutput(input string tag, input logic irdy, input logic ov,
                               input logic [CW-1:0] oc);
        chk({tag, "_in_ready"},  160'(in_ready),  160'(irdy));
        chk({tag, "_out_valid"}, 160'(out_valid), 160'(ov));
        chk({tag, "_out_ctrl"},  160'(out_ctrl),  160'(oc));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [PW-1:0] dA, dB, dC, d11, d22, d33;
        int wait_cnt;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        cycle();
        rst = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0);
            checkOutput("idle", 1'b1, 1'b0, 16'h0000);
            chk("idle_out_data", 160'(out_data), 160'(0));
        end
`ifdef PIPE_PERF_EN
        chk("idle_bubble_cnt", 160'(bubble_cnt), 160'(3));
`endif

        $display("[TB] streaming");
        d11 = mkData(); d22 = mkData(); d33 = mkData();
        applyStimulus(1'b1, 16'h0011, d11, 1'b1);
        checkOutput("s1", 1'b1, 1'b1, 16'h0011);
        chk("s1_data", 160'(out_data), 160'(d11));
        applyStimulus(1'b1, 16'h0022, d22, 1'b1);
        checkOutput("s2", 1'b1, 1'b1, 16'h0022);
        applyStimulus(1'b1, 16'h0033, d33, 1'b1);
        checkOutput("s3", 1'b1, 1'b1, 16'h0033);
        chk("s3_data", 160'(out_data), 160'(d33));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("s_end", 1'b1, 1'b0, 16'h0000);

        $display("[TB] back-pressure");
        dA = mkData(); dB = mkData();
        applyStimulus(1'b1, 16'h00A1, dA, 1'b0);
        checkOutput("bp1", 1'b1, 1'b1, 16'h00A1);
        applyStimulus(1'b1, 16'h00B2, dB, 1'b0);
        checkOutput("bp2", 1'b0, 1'b1, 16'h00A1);
        applyStimulus(1'b1, 16'h00EE, mkData(), 1'b0);
        checkOutput("bp_hold", 1'b0, 1'b1, 16'h00A1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("bp_a_out", 1'b1, 1'b1, 16'h00B2);
        chk("bp_b_data", 160'(out_data), 160'(dB));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("bp_b_out", 1'b1, 1'b0, 16'h0000);

        $display("[TB] flush with both entries full");
        dA = mkData(); dC = mkData();
        applyStimulus(1'b1, 16'h0044, dA, 1'b0);
        applyStimulus(1'b1, 16'h0055, mkData(), 1'b0);
        checkOutput("fl_full", 1'b0, 1'b1, 16'h0044);
        flush = 1'b1;
        applyStimulus(1'b1, 16'h00C3, dC, 1'b0);
        flush = 1'b0;
        checkOutput("fl_after", 1'b1, 1'b0, 16'h0000);
        chk("fl_data_held", 160'(out_data), 160'(dA));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            checkOutput("fl_no_c", 1'b1, 1'b0, 16'h0000);
        end

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 16'h0066, mkData(), 1'b0);
        applyStimulus(1'b1, 16'h0077, mkData(), 1'b0);
        checkOutput("rm_full", 1'b0, 1'b1, 16'h0066);
        rst = 1'b1; flush = 1'b1;
        applyStimulus(1'b1, 16'h0088, mkData(), 1'b0);
        rst = 1'b0; flush = 1'b0;
        checkOutput("rm_after", 1'b1, 1'b0, 16'h0000);
        chk("rm_out_data", 160'(out_data), 160'(0));
`ifdef PIPE_PERF_EN
        chk("rm_stall_cnt", 160'(stall_cnt), 160'(0));
        chk("rm_bubble_cnt", 160'(bubble_cnt), 160'(0));
`endif
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("rm_idle", 1'b1, 1'b0, 16'h0000);

`ifdef PIPE_PERF_EN
        $display("[TB] stall counter saturation");
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 16'h0099, mkData(), 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, '0, 1'b0);
        chk("sat_stall_20", 160'(stall_cnt), 160'(15));
        applyStimulus(1'b0, '0, '0, 1'b0);
        chk("sat_stall_21", 160'(stall_cnt), 160'(15));
        chk("sat_bubble", 160'(bubble_cnt), 160'(1));
`endif

        // Drain whatever remains and confirm nothing was lost.
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 10) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            wait_cnt++;
        end
        chk("drain_sb_empty", 160'(sb.size()), 160'(0));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("final", 1'b1, 1'b0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_elastic_reg.md
Name: id_ex_elastic_reg

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline register.
- Carries a control vector and a data payload from decode to execute with a valid/ready handshake.
- 2-entry skid buffer provides full throughput under back-pressure; flush inserts bubbles for branch mispredict and trap.
- Control bits are forced to zero whenever an entry is empty, so an empty slot is a true no-op (no RegWrite/MemWrite).

Parameters:
- DATA_WIDTH, 32, width of each data field word (RD1, RD2, ImmExt, PC).
- NUM_WORDS, 4, number of DATA_WIDTH words in the payload. Payload width is NUM_WORDS*DATA_WIDTH.
- CTRL_WIDTH, 16, width of the control vector (RegWrite, ResultSrc, MemWrite, ALUctrl, ALUSrc, funct3, rd ...). Zeroed on bubble.
- CNT_WIDTH, 16, perf counter width (only with PIPE_PERF_EN).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all held entries at next edge.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage can accept. Registered: equals !skid_valid.
- in_ctrl  in  CTRL_WIDTH  decoded control.
- in_data  in  NUM_WORDS*DATA_WIDTH  payload.
- out_valid  out  1  execute-side entry valid (main_valid).
- out_ready  in  1  execute consumes.
- out_ctrl  out  CTRL_WIDTH  main control. 0 whenever out_valid=0.
- out_data  out  NUM_WORDS*DATA_WIDTH  main payload. Holds last value when invalid.
- stall_cnt  out  CNT_WIDTH  (PIPE_PERF_EN only).
- bubble_cnt  out  CNT_WIDTH  (PIPE_PERF_EN only).

Behaviour:
- State: main entry {main_valid, main_ctrl, main_data}; skid entry {skid_valid, skid_ctrl, skid_data}.
- acc = in_valid & in_ready.
- cons = out_valid & out_ready.
- Reset (rst=1 at edge): both valids=0, both ctrl=0, both data=0, counters=0. Outputs after reset: in_ready=1, out_valid=0, out_ctrl=0, out_data=0.
- Priority: rst > flush > normal operation.
- flush=1: both valids=0 and both ctrls=0; data registers are unchanged. Any acc in the same cycle is dropped. Next cycle in_ready=1 and out_valid=0.
- Normal update when main is empty or cons=1:
  - skid_valid=1: main <= skid; skid empties (valid=0, ctrl=0). Any acc in that cycle is impossible because in_ready=0.
  - else if acc: main <= input, main_valid=1.
  - else: main_valid=0, main_ctrl=0.
- Normal update when main is full and cons=0:
  - if acc: skid <= input, skid_valid=1 (skid must have been empty because in_ready=1).
  - main is held.
- Latency: 1 cycle from acc to out_valid when main is empty/consumed.
- Throughput: 1 per cycle while out_ready=1.
- Ordering: strictly FIFO. No loss and no duplication except on flush.
- Boundary: both entries full means in_ready=0. in_ready only returns to 1 the cycle after a cons moves skid into main.
- Boundary: a simultaneous cons and acc with main full and skid empty passes the new input straight into main (skid stays empty).
- Signals must not combinationally depend on out_ready/in_valid: in_ready, out_valid, out_ctrl, out_data are all pure register outputs.

Optional Feature:
- Macro PIPE_PERF_EN.
- Defined: stall_cnt and bubble_cnt ports exist.
  - stall_cnt increments on cycles with out_valid & !out_ready.
  - bubble_cnt increments on cycles with !out_valid.
  - Both saturate at all-ones.
  - Both are cleared by rst only (not by flush).
- Undefined: counter ports and logic are absent. Datapath behaviour is identical.

Test Plan:
- Reset then idle, checked for 3 cycles: in_ready=1, out_valid=0, out_ctrl=0, out_data=0 (PIPE_PERF_EN: bubble_cnt=3).
- Streaming, out_ready=1, inputs ctrl=0x0011/0x0022/0x0033 on consecutive cycles: each appears on out_ctrl exactly 1 cycle later, in order, with out_valid=1 for 3 consecutive cycles.
- Back-pressure: send A=0x00A1, B=0x00B2 with out_ready=0. After 2 cycles out_ctrl=0x00A1 and in_ready=0. Raise out_ready: A then B emerge on consecutive cycles, and in_ready=1 the cycle after A is consumed.
- Flush with both entries full: assert flush for 1 cycle while in_valid=1 offers C=0x00C3. Next cycle out_valid=0, out_ctrl=0, in_ready=1. C never appears at the output.
- Reset mid-operation: main and skid full, rst=1 together with flush=1 and in_valid=1. All state clears, and the following output matches the reset scenario.
- PIPE_PERF_EN saturation, with CNT_WIDTH=4: hold out_valid=1, out_ready=0 for 20 cycles. stall_cnt=15 and stays at 15.
